instr_encoder: RTL and testbench

Sequential instruction encoder. It is the producer side of the 16-bit CPU instruction word that the control decoder consumes. It accepts abstract operation requests (op class, register fields, immediate) over a valid/ready handshake and emits encoded 16-bit instruction words over a second valid/ready handshake. It feeds the instruction-memory loader and the self-test program generator. Some requests expand into several words: the LDI pseudo-op, and branch delay padding.

---
 rtl/instr_encoder_if.sv | 28 ++
 rtl/instr_encoder.sv | 200 ++++++++++++++++++++
 tb/tb_instr_encoder.sv | 283 ++++++++++++++++++++++++++++
 3 files changed

// File: rtl/instr_encoder_if.sv
// Request and instruction-word handshakes of the instruction encoder.
interface instr_encoder_if;
  logic        req_valid;
  logic        req_ready;
  logic [4:0]  req_op;
  logic [2:0]  req_rd;
  logic [2:0]  req_rn;
  logic [2:0]  req_rm;
  logic [3:0]  req_cond;
  logic [15:0] req_imm;
  logic        instr_valid;
  logic        instr_ready;
  logic [15:0] instr;
  logic        busy;
  logic        err;

  // Request producer / instruction consumer side
  modport master (
    output req_valid, req_op, req_rd, req_rn, req_rm, req_cond, req_imm, instr_ready,
    input  req_ready, instr_valid, instr, busy, err
  );

  // Encoder side
  modport slave (
    input  req_valid, req_op, req_rd, req_rn, req_rm, req_cond, req_imm, instr_ready,
    output req_ready, instr_valid, instr, busy, err
  );
endinterface

// File: rtl/instr_encoder.sv
// Sequential instruction encoder: turns abstract operation requests into
// 16-bit instruction words, expanding LDI and padding branches with NOPs.
module instr_encoder #(
  parameter int unsigned PAD_NOPS    = 2,
  parameter int unsigned SCRATCH_REG = 7
) (
  input  logic            clk,
  input  logic            reset,
  instr_encoder_if.slave  bus
);

  localparam logic [15:0] NOP  = 16'hBF00;
  localparam logic [2:0]  SCR  = SCRATCH_REG[2:0];
  localparam logic [2:0]  PADN = PAD_NOPS[2:0];

  // Single words never occupy a state of their own: they return to IDLE in
  // the accept cycle, which is what keeps back-to-back throughput at 1/cycle.
  typedef enum logic [1:0] {IDLE, EXPAND, PAD} state_t;

  state_t      state_q, state_d;
  logic [2:0]  step_q, step_d;
  logic [2:0]  pad_q, pad_d;
  logic [15:0] instr_q, instr_d;
  logic        valid_q, valid_d;
  logic        err_q, err_d;
  logic [2:0]  rd_q, rd_d;
  logic [7:0]  lo_q, lo_d;

  logic advance, req_ready, accept, ldi_long, req_legal, is_branch;

  function automatic logic [15:0] encode(input logic [4:0]  op,
                                         input logic [2:0]  rd,
                                         input logic [2:0]  rn,
                                         input logic [2:0]  rm,
                                         input logic [3:0]  cond,
                                         input logic [15:0] imm);
    logic [15:0] w;
    w = NOP;
    case (op)
      5'd0:  w = {5'b00100, rd, imm[7:0]};
      5'd1:  w = {7'b0001110, imm[2:0], rn, rd};
      5'd2:  w = {7'b0001100, rm, rn, rd};
      5'd3:  w = {7'b0001111, imm[2:0], rn, rd};
      5'd4:  w = {7'b0001101, rm, rn, rd};
      5'd5:  w = {10'b0100001010, rm, rn};
      5'd6:  w = {10'b0100000000, rm, rd};
      5'd7:  w = {10'b0100000001, rm, rd};
      5'd8:  w = {10'b0100001100, rm, rd};
      5'd9:  w = {10'b0100001111, rm, rd};
      5'd10: w = {10'b0100000010, rm, rd};
      5'd11: w = {10'b0100000011, rm, rd};
      5'd12: w = {10'b0100000100, rm, rd};
      5'd13: w = {10'b0100000111, rm, rd};
      5'd14: w = {5'b01100, imm[4:0], rn, rd};
      5'd15: w = {5'b01101, imm[4:0], rn, rd};
      5'd16: w = {4'b1101, cond, imm[7:0]};
      5'd17: w = {5'b11100, imm[10:0]};
      5'd18: w = NOP;
      // FADD..FDIV are ops 19..22; low two op bits plus one give 00..11
      5'd19, 5'd20, 5'd21, 5'd22: w = {5'b01110, op[1:0] + 2'd1, rm, rn, rd};
      5'd23: w = {5'b00100, rd, (imm[15:8] != '0) ? imm[15:8] : imm[7:0]};
      default: w = NOP;
    endcase
    return w;
  endfunction

  // Words 2..5 of the long LDI expansion, indexed by step
  function automatic logic [15:0] expand_word(input logic [2:0] step,
                                              input logic [2:0] rd,
                                              input logic [7:0] lo);
    logic [15:0] w;
    case (step)
      3'd1:    w = {5'b00100, SCR, 8'd8};
      3'd2:    w = {10'b0100000010, SCR, rd};
      3'd3:    w = {5'b00100, SCR, lo};
      default: w = {10'b0100001100, SCR, rd};
    endcase
    return w;
  endfunction

  assign advance   = !valid_q || bus.instr_ready;
  assign req_ready = (state_q == IDLE) && advance;
  assign accept    = bus.req_valid && req_ready;
  assign ldi_long  = (bus.req_op == 5'd23) && (bus.req_imm[15:8] != '0);
  assign req_legal = (bus.req_op <= 5'd23) && !(ldi_long && (bus.req_rd == SCR));
  assign is_branch = (bus.req_op == 5'd16) || (bus.req_op == 5'd17);

  // State and datapath registers
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      state_q <= IDLE;
      step_q  <= '0;
      pad_q   <= '0;
      instr_q <= '0;
      valid_q <= 1'b0;
      err_q   <= 1'b0;
      rd_q    <= '0;
      lo_q    <= '0;
    end else begin
      state_q <= state_d;
      step_q  <= step_d;
      pad_q   <= pad_d;
      instr_q <= instr_d;
      valid_q <= valid_d;
      err_q   <= err_d;
      rd_q    <= rd_d;
      lo_q    <= lo_d;
    end
  end

  // Next-state: sequence selection and step/pad counters
  always_comb begin
    state_d = state_q;
    step_d  = step_q;
    pad_d   = pad_q;
    case (state_q)
      IDLE: begin
        if (accept && req_legal) begin
          if (ldi_long) begin
            state_d = EXPAND;
            step_d  = '0;
          end else if (is_branch && (PADN != '0)) begin
            state_d = PAD;
            pad_d   = PADN;
          end
        end
      end
      EXPAND: begin
        if (advance) begin
          if (step_q == 3'd4) begin
            state_d = IDLE;
            step_d  = '0;
          end else begin
            step_d = step_q + 3'd1;
          end
        end
      end
      PAD: begin
        if (advance) begin
          if (pad_q == '0) state_d = IDLE;
          else             pad_d   = pad_q - 3'd1;
        end
      end
      default: state_d = IDLE;
    endcase
  end

  // Output word, valid flag, error pulse and captured LDI operands
  always_comb begin
    instr_d = instr_q;
    valid_d = valid_q;
    err_d   = 1'b0;
    rd_d    = rd_q;
    lo_d    = lo_q;
    case (state_q)
      IDLE: begin
        if (advance) valid_d = 1'b0;
        if (accept) begin
          if (!req_legal) begin
            err_d = 1'b1;
          end else begin
            valid_d = 1'b1;
            instr_d = encode(bus.req_op, bus.req_rd, bus.req_rn, bus.req_rm,
                             bus.req_cond, bus.req_imm);
            rd_d    = bus.req_rd;
            lo_d    = bus.req_imm[7:0];
          end
        end
      end
      EXPAND: begin
        if (advance) begin
          if (step_q == 3'd4) begin
            valid_d = 1'b0;
          end else begin
            valid_d = 1'b1;
            instr_d = expand_word(step_q + 3'd1, rd_q, lo_q);
          end
        end
      end
      PAD: begin
        if (advance) begin
          if (pad_q == '0) begin
            valid_d = 1'b0;
          end else begin
            valid_d = 1'b1;
            instr_d = NOP;
          end
        end
      end
      default: valid_d = 1'b0;
    endcase
  end

  assign bus.req_ready   = req_ready;
  assign bus.instr_valid = valid_q;
  assign bus.instr       = instr_q;
  assign bus.busy        = (state_q == EXPAND) || (state_q == PAD);
  assign bus.err         = err_q;

endmodule

// File: tb/tb_instr_encoder.sv
// Scoreboard bench for instr_encoder: driver pushes expected words from a
// reference model, an independent monitor pops and compares.
module tb_instr_encoder;

  localparam int unsigned PADN = 2;
  localparam int unsigned SCR  = 7;

  logic clk;
  logic reset;
  instr_encoder_if bus();

  instr_encoder #(.PAD_NOPS(PADN), .SCRATCH_REG(SCR)) dut (
    .clk   (clk),
    .reset (reset),
    .bus   (bus)
  );

  int checks = 0;
  int errors = 0;
  int popped = 0;
  logic [15:0] exp_q[$];

  logic rnd_ready  = 1'b0;
  logic manual_rdy = 1'b1;

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic chk(input string name, input logic [15:0] act, input logic [15:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s actual=%h expected=%h at %0t", name, act, exp, $time);
    end
  endtask

  // Reference model rules
  function automatic logic [15:0] movs(input int unsigned r, input int unsigned v);
    return 16'(32'h2000 | (r << 8) | (v & 255));
  endfunction

  function automatic logic [15:0] alu(input int unsigned idx, input int unsigned rm, input int unsigned rd);
    int unsigned tbl[8] = '{'h100, 'h101, 'h10C, 'h10F, 'h102, 'h103, 'h104, 'h107};
    return 16'((tbl[idx] << 6) | (rm << 3) | rd);
  endfunction

  function automatic bit is_illegal(input int unsigned op, input int unsigned rd, input int unsigned imm);
    return (op > 23) || (op == 23 && (imm >> 8) != 0 && rd == SCR);
  endfunction

  // Pushes the expected word sequence for one request; returns word count
  function automatic int push_model(input int unsigned op, input int unsigned rd, input int unsigned rn,
                                    input int unsigned rm, input int unsigned cond, input int unsigned imm);
    int unsigned w;
    int n = 0;
    if (is_illegal(op, rd, imm)) return 0;
    if (op == 23) begin
      if ((imm >> 8) == 0) begin
        exp_q.push_back(movs(rd, imm)); n = 1;
      end else begin
        exp_q.push_back(movs(rd, imm >> 8));
        exp_q.push_back(movs(SCR, 8));
        exp_q.push_back(alu(4, SCR, rd));
        exp_q.push_back(movs(SCR, imm));
        exp_q.push_back(alu(2, SCR, rd));
        n = 5;
      end
      return n;
    end
    case (op)
      0:              w = movs(rd, imm);
      1:              w = ('h0E << 9) | ((imm & 7) << 6) | (rn << 3) | rd;
      2:              w = ('h0C << 9) | (rm << 6) | (rn << 3) | rd;
      3:              w = ('h0F << 9) | ((imm & 7) << 6) | (rn << 3) | rd;
      4:              w = ('h0D << 9) | (rm << 6) | (rn << 3) | rd;
      5:              w = ('h10A << 6) | (rm << 3) | rn;
      14:             w = ('h0C << 11) | ((imm & 31) << 6) | (rn << 3) | rd;
      15:             w = ('h0D << 11) | ((imm & 31) << 6) | (rn << 3) | rd;
      16:             w = 'hD000 | (cond << 8) | (imm & 255);
      17:             w = 'hE000 | (imm & 'h7FF);
      18:             w = 'hBF00;
      19, 20, 21, 22: w = 'h7000 | ((op - 19) << 9) | (rm << 6) | (rn << 3) | rd;
      default:        w = alu(op - 6, rm, rd);
    endcase
    exp_q.push_back(16'(w)); n = 1;
    if (op == 16 || op == 17)
      for (int unsigned i = 0; i < PADN; i++) begin exp_q.push_back(16'hBF00); n++; end
    return n;
  endfunction

  // Consumer-ready generator
  initial begin
    bus.instr_ready = 1'b1;
    forever begin
      @(posedge clk); #1;
      bus.instr_ready = rnd_ready ? ($urandom_range(0, 3) != 0) : manual_rdy;
    end
  end

  // Monitor: pops the scoreboard on every consumed word, checks hold and err
  logic pend_err = 1'b0;
  logic hold_q = 1'b0;
  logic [15:0] hold_w = '0;
  always @(negedge clk) begin
    if (!reset) begin
      pend_err = 1'b0;
      hold_q   = 1'b0;
    end else begin
      chk("err", {15'd0, bus.err}, {15'd0, pend_err});
      if (hold_q) begin
        chk("hold_valid", {15'd0, bus.instr_valid}, 16'd1);
        chk("hold_instr", bus.instr, hold_w);
      end
      if (bus.instr_valid && bus.instr_ready) begin
        if (exp_q.size() == 0) begin
          checks++; errors++;
          $display("FAIL word unexpected actual=%h expected=none at %0t", bus.instr, $time);
        end else begin
          chk("word", bus.instr, exp_q.pop_front());
        end
        popped++;
      end
      hold_q   = bus.instr_valid && !bus.instr_ready;
      hold_w   = bus.instr;
      pend_err = bus.req_valid && bus.req_ready &&
                 is_illegal(bus.req_op, bus.req_rd, bus.req_imm);
    end
  end

  // Present one request until accepted; returns at posedge+1 after accept
  task automatic issue(input int unsigned op, input int unsigned rd, input int unsigned rn,
                       input int unsigned rm, input int unsigned cond, input int unsigned imm,
                       output int waited);
    int n;
    bus.req_op   = 5'(op);
    bus.req_rd   = 3'(rd);
    bus.req_rn   = 3'(rn);
    bus.req_rm   = 3'(rm);
    bus.req_cond = 4'(cond);
    bus.req_imm  = 16'(imm);
    bus.req_valid = 1'b1;
    waited = 0;
    forever begin
      @(negedge clk);
      if (bus.req_ready) begin
        n = push_model(op, rd, rn, rm, cond, imm);
        break;
      end
      waited++;
      if (waited > 200) begin
        checks++; errors++;
        $display("FAIL accept_timeout actual=waited expected=accept op=%0d", op);
        break;
      end
    end
    @(posedge clk); #1;
    bus.req_valid = 1'b0;
  endtask

  task automatic drain();
    int c = 0;
    while (exp_q.size() != 0 && c < 500) begin @(negedge clk); c++; end
    chk("drain_empty", 16'(exp_q.size()), 16'd0);
    @(posedge clk); #1;
  endtask

  initial begin
    int w;
    int c;
    bus.req_valid = 1'b0;
    bus.req_op = '0; bus.req_rd = '0; bus.req_rn = '0; bus.req_rm = '0;
    bus.req_cond = '0; bus.req_imm = '0;
    reset = 1'b0;
    #1;
    chk("rst_valid", {15'd0, bus.instr_valid}, 16'd0);
    chk("rst_instr", bus.instr, 16'h0000);
    chk("rst_busy",  {15'd0, bus.busy}, 16'd0);
    chk("rst_err",   {15'd0, bus.err}, 16'd0);
    chk("rst_ready", {15'd0, bus.req_ready}, 16'd1);
    repeat (2) @(posedge clk);
    #3 reset = 1'b1;
    @(posedge clk); #1;

    // Back-to-back single words with latency check
    issue(2, 1, 2, 3, 0, 0, w);
    chk("adds_valid", {15'd0, bus.instr_valid}, 16'd1);
    chk("adds_word", bus.instr, 16'h18D1);
    issue(21, 0, 1, 2, 0, 0, w);
    chk("fmul_no_bubble", 16'(w), 16'd0);
    chk("fmul_word", bus.instr, 16'h7488);
    drain();

    // LDI expansion with backpressure on word 3
    issue(23, 2, 0, 0, 0, 'h1234, w);
    chk("ldi_busy", {15'd0, bus.busy}, 16'd1);
    c = 0;
    while (!(bus.instr_valid && bus.instr == 16'h2708) && c < 50) begin @(negedge clk); c++; end
    chk("ldi_w2_seen", bus.instr, 16'h2708);
    manual_rdy = 1'b0;
    @(posedge clk);
    for (int i = 0; i < 4; i++) begin
      @(negedge clk);
      chk("bp_instr", bus.instr, 16'h40BA);
      chk("bp_valid", {15'd0, bus.instr_valid}, 16'd1);
      chk("bp_busy", {15'd0, bus.busy}, 16'd1);
      chk("bp_req_ready", {15'd0, bus.req_ready}, 16'd0);
    end
    manual_rdy = 1'b1;
    drain();
    chk("ldi_idle_busy", {15'd0, bus.busy}, 16'd0);
    issue(23, 3, 0, 0, 0, 'h0042, w);
    chk("ldi_short", bus.instr, 16'h2342);
    chk("ldi_short_busy", {15'd0, bus.busy}, 16'd0);

    // Branch padding
    issue(16, 0, 0, 0, 1, 'h05, w);
    chk("bcond_word", bus.instr, 16'hD105);
    issue(17, 0, 0, 0, 0, 'h7FF, w);
    drain();

    // Illegal requests
    issue(25, 0, 0, 0, 0, 0, w);
    chk("ill_err", {15'd0, bus.err}, 16'd1);
    chk("ill_valid", {15'd0, bus.instr_valid}, 16'd0);
    @(posedge clk); #1;
    chk("ill_err_end", {15'd0, bus.err}, 16'd0);
    chk("ill_ready", {15'd0, bus.req_ready}, 16'd1);
    issue(23, 7, 0, 0, 0, 'h0100, w);
    chk("ldi7_err", {15'd0, bus.err}, 16'd1);
    chk("ldi7_valid", {15'd0, bus.instr_valid}, 16'd0);
    @(posedge clk); #1;
    chk("ldi7_ready", {15'd0, bus.req_ready}, 16'd1);

    // Reset in the middle of an LDI
    issue(23, 2, 0, 0, 0, 'h1234, w);
    c = 0;
    while (!(bus.instr_valid && bus.instr == 16'h2708) && c < 50) begin @(negedge clk); c++; end
    @(posedge clk);
    #3 reset = 1'b0;
    #1;
    chk("mid_rst_valid", {15'd0, bus.instr_valid}, 16'd0);
    chk("mid_rst_busy", {15'd0, bus.busy}, 16'd0);
    chk("mid_rst_instr", bus.instr, 16'h0000);
    exp_q.delete();
    @(posedge clk); #1;
    chk("rst_hold_valid", {15'd0, bus.instr_valid}, 16'd0);
    @(posedge clk);
    #3 reset = 1'b1;
    @(posedge clk); #1;
    chk("post_rst_valid", {15'd0, bus.instr_valid}, 16'd0);
    issue(0, 0, 0, 0, 0, 'hFF, w);
    chk("post_rst_movs", bus.instr, 16'h20FF);
    drain();

    // Randomized traffic with random consumer backpressure
    rnd_ready = 1'b1;
    for (int k = 0; k < 300; k++) begin
      int unsigned op, imm, r;
      r = $urandom_range(0, 9);
      if (r < 2)       op = 23;
      else if (r < 3)  op = 16 + $urandom_range(0, 1);
      else             op = $urandom_range(0, 31);
      imm = $urandom_range(0, 65535);
      if (op == 23 && $urandom_range(0, 2) == 0) imm = imm & 255;
      issue(op, $urandom_range(0, 7), $urandom_range(0, 7), $urandom_range(0, 7),
            $urandom_range(0, 15), imm, w);
      if ($urandom_range(0, 3) == 0) begin @(posedge clk); #1; end
    end
    drain();
    rnd_ready = 1'b0;
    @(posedge clk); #1;

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

  initial begin
    #2000000;
    $display("FAIL global_timeout actual=running expected=finished");
    $fatal(1);
  end

endmodule
